// File: rtl/mux16_arb_pkg.sv
// Shared types and sizes for the 16-slot round-robin mux arbiter.
// Imported by rr_pick16 and mux16_rr_arbiter.
package mux16_arb_pkg;

    localparam int NSLOT = 16;
    localparam int SELW  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/Mux16to1_8bit.sv
// Shared 16:1 byte mux: slot i occupies data_in[8*i+7:8*i].
module Mux16to1_8bit (
    input  logic [127:0] data_in,
    input  logic [3:0]   sel,
    output logic [7:0]   data_out
);

    always_comb begin
        data_out = data_in[{sel, 3'b000} +: 8];
    end

endmodule

// File: rtl/rr_pick16.sv
// Round-robin winner search over 16 requests starting at ptr, wrapping 15->0.
// Rotates so ptr lands at bit 0, takes the lowest set bit, then rotates back.
module rr_pick16
    import mux16_arb_pkg::*;
(
    input  logic [NSLOT-1:0] req,
    input  logic [SELW-1:0]  ptr,
    output logic             found,
    output logic [SELW-1:0]  idx
);

    logic [NSLOT-1:0] rot;
    logic [SELW-1:0]  off;

    always_comb begin
        rot = '0;
        for (int i = 0; i < NSLOT; i++) begin
            rot[i] = req[ptr + SELW'(i)];
        end
    end

    // Scanning downward leaves the smallest offset, i.e. the slot nearest ptr.
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = SELW'(i);
            end
        end
    end

    assign idx = ptr + off;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter/sequencer in front of Mux16to1_8bit with a valid/ready output.
// Optional grant-revoke timeout under backpressure: define MUX16_ARB_TIMEOUT_EN.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSLOT-1:0]       req,
    input  logic [NSLOT*WIDTH-1:0] data_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        select,
    output logic [NSLOT-1:0]       ack,
    output logic                   busy
`ifdef MUX16_ARB_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    if (WIDTH != 8) begin : g_bad_width
        $error("mux16_rr_arbiter: WIDTH must be 8 to match Mux16to1_8bit");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mux16_rr_arbiter: TIMEOUT must be in 1..255");
    end

    arb_state_t      state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] select_q, select_d;
    logic            pickFound;
    logic [SELW-1:0] pickIdx;

`ifdef MUX16_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
    logic [7:0] stall_q, stall_d;
`endif

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pickFound),
        .idx   (pickIdx)
    );

    // The mux select is the registered grantee so the datapath never glitches mid-grant.
    Mux16to1_8bit u_mux (
        .data_in  (data_in),
        .sel      (select_q),
        .data_out (out_data)
    );

    assign select = select_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            select_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            select_q <= select_d;
        end
    end

`ifdef MUX16_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    // Arbitration only happens in IDLE; a GRANT always returns through IDLE,
    // which gives the one-cycle bubble after every transfer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        select_d  = select_q;
        out_valid = 1'b0;
        ack       = '0;
        busy      = 1'b0;
`ifdef MUX16_ARB_TIMEOUT_EN
        stall_d     = stall_q;
        timeout_err = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    select_d = pickIdx;
                    state_d  = GRANT;
`ifdef MUX16_ARB_TIMEOUT_EN
                    stall_d  = '0;
`endif
                end
            end

            GRANT: begin
                busy      = 1'b1;
                out_valid = req[select_q];
                if (!req[select_q]) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    ack[select_q] = 1'b1;
                    ptr_d         = select_q + SELW'(1);
                    state_d       = IDLE;
                end
`ifdef MUX16_ARB_TIMEOUT_EN
                else begin
                    stall_d = stall_q + 8'd1;
                    if (stall_d == TIMEOUT_LIM) begin
                        ptr_d       = select_q + SELW'(1);
                        state_d     = IDLE;
                        timeout_err = 1'b1;
                    end
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: reset, single grants, round-robin order,
// wrap-around, backpressure, withdraw; acks are checked against a scoreboard queue.
module tb_mux16_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  req;
    logic [127:0] data_in;
    logic         out_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic [3:0]   select;
    logic [15:0]  ack;
    logic         busy;
`ifdef MUX16_ARB_TIMEOUT_EN
    logic         timeout_err;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] req;
        int          expSel;
    } vec_t;

    typedef struct {
        int         slot;
        logic [7:0] data;
    } exp_t;

    vec_t vecs[7];
    exp_t sbq[$];

    mux16_rr_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data_in     (data_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .select      (select),
        .ack         (ack),
        .busy        (busy)
`ifdef MUX16_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] wordOf(input int i);
        logic [3:0] n;
        n = 4'(i);
        return {~n, n};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
    endtask

    task automatic pushExp(input int slot);
        exp_t e;
        e.slot = slot;
        e.data = wordOf(slot);
        sbq.push_back(e);
    endtask

    task automatic expectGrant(input string tag, input int slot, input logic withAck);
        checkOutput({tag, "_sel"},   32'(select),    32'(slot));
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_data"},  32'(out_data),  32'(wordOf(slot)));
        checkOutput({tag, "_busy"},  32'(busy),      32'd1);
        checkOutput({tag, "_ack"},   32'(ack),       withAck ? (32'd1 << slot) : 32'd0);
    endtask

    task automatic expectIdle(input string tag);
        checkOutput({tag, "_busy"},  32'(busy),      32'd0);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_ack"},   32'(ack),       32'd0);
    endtask

    // Every ack must match the oldest outstanding expected transfer, slot and word.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && ack !== 16'h0000) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_unexpected_ack: got=%0h expected=none", ack);
            end else begin
                e = sbq.pop_front();
                checkOutput("sb_ack",  32'(ack),      32'd1 << e.slot);
                checkOutput("sb_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) data_in[8*i +: 8] = wordOf(i);
        rst = 1'b1;
        applyStimulus(16'h0000, 1'b0);

        vecs[0] = '{16'h0041, 6};
        vecs[1] = '{16'h0041, 0};
        vecs[2] = '{16'h8000, 15};
        vecs[3] = '{16'h0003, 0};
        vecs[4] = '{16'h0003, 1};
        vecs[5] = '{16'h0101, 8};
        vecs[6] = '{16'hFFFF, 9};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid",  32'(out_valid), 32'd0);
        checkOutput("rst_select", 32'(select),    32'd0);
        checkOutput("rst_ack",    32'(ack),       32'd0);
        checkOutput("rst_busy",   32'(busy),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] single request on slot 5");
        applyStimulus(16'h0020, 1'b1);
        pushExp(5);
        @(posedge clk);
        @(negedge clk);
        expectGrant("t2", 5, 1'b1);
        checkOutput("t2_a5", 32'(out_data), 32'h0000_00A5);
        @(posedge clk); #1;
        applyStimulus(16'h0000, 1'b1);
        @(negedge clk);
        expectIdle("t2_idle");

        $display("[TB] table of single transfers");
        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[v].req, 1'b1);
            pushExp(vecs[v].expSel);
            @(posedge clk);
            @(negedge clk);
            expectGrant($sformatf("vec%0d", v), vecs[v].expSel, 1'b1);
            @(posedge clk); #1;
            applyStimulus(16'h0000, 1'b1);
            @(negedge clk);
            expectIdle($sformatf("vec%0d_idle", v));
        end

        $display("[TB] reset in the middle of a grant");
        @(posedge clk); #1;
        applyStimulus(16'hFFFF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        expectGrant("t1_pre", 10, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t1_valid",  32'(out_valid), 32'd0);
        checkOutput("t1_select", 32'(select),    32'd0);
        checkOutput("t1_ack",    32'(ack),       32'd0);
        checkOutput("t1_busy",   32'(busy),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        $display("[TB] all requests held: rotation 0..15,0");
        @(posedge clk);
        for (int k = 0; k < 17; k++) begin
            pushExp(k % 16);
            @(negedge clk);
            expectGrant($sformatf("t3_g%0d", k), k % 16, 1'b1);
            @(negedge clk);
            expectIdle($sformatf("t3_b%0d", k));
        end

        $display("[TB] wrap from slot 15 to slot 2");
        applyStimulus(16'h4000, 1'b1);
        pushExp(14);
        @(negedge clk);
        expectGrant("t4_g14", 14, 1'b1);
        @(posedge clk); #1;
        applyStimulus(16'h8004, 1'b1);
        pushExp(15);
        @(posedge clk);
        @(negedge clk);
        expectGrant("t4_g15", 15, 1'b1);
        @(posedge clk); #1;
        applyStimulus(16'h0004, 1'b1);
        pushExp(2);
        @(posedge clk);
        @(negedge clk);
        expectGrant("t4_g2", 2, 1'b1);
        @(posedge clk); #1;
        applyStimulus(16'h0000, 1'b0);
        @(negedge clk);
        expectIdle("t4_idle");

        $display("[TB] backpressure on slot 3");
        @(posedge clk); #1;
        applyStimulus(16'h0008, 1'b0);
        @(posedge clk);
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            expectGrant($sformatf("t5_stall%0d", s), 3, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        pushExp(3);
        @(negedge clk);
        expectGrant("t5_ack", 3, 1'b1);
        @(posedge clk); #1;
        applyStimulus(16'h0000, 1'b0);
        @(negedge clk);
        expectIdle("t5_idle");

        $display("[TB] request withdrawn during grant");
        @(posedge clk); #1;
        applyStimulus(16'h0200, 1'b0);
        @(posedge clk);
        @(negedge clk);
        expectGrant("t6_g9", 9, 1'b0);
        @(posedge clk); #1;
        applyStimulus(16'h0000, 1'b1);
        #1;
        checkOutput("t6_valid_now", 32'(out_valid), 32'd0);
        checkOutput("t6_busy_now",  32'(busy),      32'd1);
        checkOutput("t6_ack_now",   32'(ack),       32'd0);
        @(posedge clk);
        @(negedge clk);
        expectIdle("t6_idle");
        @(posedge clk); #1;
        applyStimulus(16'h0021, 1'b1);
        pushExp(5);
        @(posedge clk);
        @(negedge clk);
        expectGrant("t6_ptr", 5, 1'b1);
        @(posedge clk); #1;
        applyStimulus(16'h0000, 1'b0);
        @(negedge clk);
        expectIdle("t6_end");

        checkOutput("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
